ordered_frame_tx: RTL
=====================

# ordered_frame_tx

Transmit side of the positional serial link between a parent module and its instantiated children. Accepts a WIDTH-bit parallel word over a valid/ready handshake and shifts it out on a single wire as a framed serial stream. Bit position i of the word is transmitted in slot i, so the field order on the wire matches the field order on the bus. Sits between a parent's packed field bus and the serial line feeding the matching receiver.

## Interface
- WIDTH, default 3: data bits per frame; must be ≥1.
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; must be ≥1.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idle level 1.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY (only if PARITY_EN is defined), STOP.
- IDLE: tx_out=1, in_ready=1, tx_busy=0. Handshake accepts when in_valid&&in_ready at a rising edge. The accept latches in_data into a shift register, clears the bit counter and cycle counter, and moves to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_out=shift[0]. Shift right once every CLKS_PER_BIT cycles. After WIDTH bits, go to PARITY if enabled, else STOP. in_data[0] goes first (LSB first).
- PARITY: tx_out=even parity (XOR of the latched word) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE. frame_done=1 in the first IDLE cycle.
- in_ready=0 and tx_busy=1 in every state except IDLE.
- Changes to in_data or in_valid mid-frame are ignored.
- Cycle counter width is clog2(CLKS_PER_BIT), minimum 1. Bit counter width is clog2(WIDTH+1). Neither counter wraps within a bit period or frame.

## Timing
- Reset values: tx_out=1, in_ready=1, tx_busy=0, frame_done=0; state IDLE; counters and shift register 0.
- Reset asserted mid-frame forces these values immediately, asynchronously. The partial frame is dropped with no frame_done.
- Accept at edge E: tx_out falls to 0 during cycle E+1.
- Frame length F = (2 + WIDTH + P) × CLKS_PER_BIT cycles, where P=1 with PARITY_EN and P=0 without.
- frame_done is high during cycle E+1+F, which is also the first IDLE cycle with in_ready=1.
- Back-to-back: a word accepted on the edge that ends the frame_done cycle starts its start bit the next cycle. There is exactly one idle-level cycle (tx_out=1) between frames.
- in_valid held high in IDLE is accepted on the next edge. in_ready never depends combinationally on in_valid.

## Configuration
- Macro ORDERED_FRAME_TX_PARITY_EN.
- Defined: PARITY state is compiled in. One even-parity bit is inserted after the data bits. F includes P=1.
- Undefined: PARITY state and the parity logic are absent. STOP follows the last data bit directly. F uses P=0.

## Test plan
Unless stated otherwise: WIDTH=3, CLKS_PER_BIT=4, PARITY_EN undefined.
- Reset values: hold rst_n=0 for 3 cycles, then release → tx_out=1, in_ready=1, tx_busy=0, frame_done=0 throughout.
- Single frame: in_data=3'b101, accepted at edge E → tx_out reads 0,1,0,1,1, each bit held 4 cycles. frame_done pulses at E+21. in_ready=0 from E+1 to E+20.
- Parity build: PARITY_EN defined, in_data=3'b011 → tx_out reads 0,1,1,0,0,1. frame_done at E+25.
- Parity build, odd word: PARITY_EN defined, in_data=3'b111 → parity bit is 1.
- Back-to-back: in_valid held high with 3'b001 then 3'b110 → second start bit begins the cycle after frame_done. Exactly one idle-level cycle between frames. Both words are serialized intact.
- Input change mid-frame: change in_data to 3'b000 during DATA → serialized bits still match the latched word.
- Reset mid-frame: pull rst_n low during DATA bit 1 → tx_out=1 immediately, no frame_done. After release, the next accepted word transmits normally.
- Edge parameters: WIDTH=1, CLKS_PER_BIT=1, in_data=1'b1 → tx_out reads 0,1,1, one cycle each. frame_done at E+4.

Source files
------------

// File: rtl/ordered_frame_tx.sv
// ordered_frame_tx
// ----------------
// Transmit side of the positional serial link. A WIDTH-bit word taken over a
// valid/ready handshake is sent LSB first on one wire, framed as
//   start(0), data[0] .. data[WIDTH-1], [even parity], stop(1)
// and each symbol is held for CLKS_PER_BIT clocks. Bit i of the word always
// lands in data slot i, so the field order on the wire matches the bus.
//
// Optional feature: define ORDERED_FRAME_TX_PARITY_EN to insert one even-parity
// bit (XOR of the latched word) between the last data bit and the stop bit.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_data     in   [WIDTH-1:0] word to send, sampled only on an accept
//   in_valid    in   in_data is valid
//   in_ready    out  block can take a word this cycle (high only in IDLE)
//   tx_out      out  serial line, idles high
//   tx_busy     out  a frame is in progress
//   frame_done  out  one-cycle pulse in the first IDLE cycle after a stop bit
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready.
// in_ready is a function of state only, never of in_valid. Once accepted the
// word is held internally, so in_data/in_valid may change freely mid-frame.

module ordered_frame_tx #(
  parameter int WIDTH        = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             frame_done
);

  // Cycle counter needs at least one bit even when CLKS_PER_BIT == 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef ORDERED_FRAME_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cyc_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;
`ifdef ORDERED_FRAME_TX_PARITY_EN
  logic             parity_q;
`endif

  logic accept;
  logic cyc_last;
  logic bit_last;

  assign accept   = (state == S_IDLE) && in_valid;
  assign cyc_last = (cyc_cnt == CYC_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and outputs. Outputs decode from state alone so that an
  // asynchronous reset forces the idle line level immediately.
  always_comb begin
    next_state = state;
    tx_out     = 1'b1;
    in_ready   = 1'b0;
    tx_busy    = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        tx_busy  = 1'b0;
        if (in_valid) next_state = S_START;
      end
      S_START: begin
        tx_out = 1'b0;
        if (cyc_last) next_state = S_DATA;
      end
      S_DATA: begin
        tx_out = shift_q[0];
        if (cyc_last && bit_last) begin
`ifdef ORDERED_FRAME_TX_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      end
`ifdef ORDERED_FRAME_TX_PARITY_EN
      S_PARITY: begin
        tx_out = parity_q;
        if (cyc_last) next_state = S_STOP;
      end
`endif
      S_STOP: begin
        tx_out = 1'b1;
        if (cyc_last) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: counters, shift register, parity and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      frame_done <= 1'b0;
`ifdef ORDERED_FRAME_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      // Registered so it shows up in the first IDLE cycle, not the last STOP one.
      frame_done <= (state == S_STOP) && cyc_last;
      if (accept) begin
        shift_q <= in_data;
        cyc_cnt <= '0;
        bit_cnt <= '0;
`ifdef ORDERED_FRAME_TX_PARITY_EN
        // The shift register is consumed during DATA, so parity is captured here.
        parity_q <= ^in_data;
`endif
      end else if (state != S_IDLE) begin
        if (cyc_last) begin
          cyc_cnt <= '0;
          if (state == S_DATA) begin
            shift_q <= shift_q >> 1;
            // Ends at WIDTH after the last bit; reloaded on the next accept.
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

endmodule
